ir_array_reader: RTL and testbench

Multi-channel reader for RC-discharge infrared reflectance sensors, the parametrised successor of the single-channel IR distance front end. Each frame drives all sensor pins high to charge their capacitors, then releases them and counts how long each stays high. The counts are scaled, saturated and published as per-channel distance bytes, with a frame-valid strobe and a per-channel threshold flag. It sits between the sensor header pins and the processor register bank, and runs in continuous or one-shot mode.

---
 rtl/ir_array_reader.sv | 182 ++++++++++++++++++
 tb/tb_ir_array_reader.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/ir_array_reader.sv
// ir_array_reader: multi-channel RC-discharge IR reflectance reader.
// Each frame charges every sensor pin, releases them, times how long each
// stays high, then publishes scaled and saturated per-channel distance bytes
// along with a one-cycle valid strobe and per-channel threshold flags.
// Assumes OUT_W <= CNT_W and PERIOD_CYC >= CHARGE_CYC + 2.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// ST_IDLE    | pins high-Z, counters at 0, waiting (one-shot) or passing through
// ST_CHARGE  | fc = 0..CHARGE_CYC-1, all pins driven high
// ST_MEASURE | fc = CHARGE_CYC..PERIOD_CYC-2, pins released, count high samples
// ST_LATCH   | fc = PERIOD_CYC-1, new distances visible, valid strobe, clear

module ir_array_reader #(
    parameter int N_CH       = 4,
    parameter int CNT_W      = 16,
    parameter int CHARGE_CYC = 65,
    parameter int PERIOD_CYC = 32750,
    parameter int OUT_W      = 8,
    parameter int SHIFT      = 0,
    parameter bit CONTINUOUS = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [OUT_W-1:0]       umbral,
    inout  wire  [N_CH-1:0]        ir_io,
    output logic                   descarga,
    output logic                   busy,
    output logic                   valid,
    output logic [N_CH*OUT_W-1:0]  distancia,
    output logic [N_CH-1:0]        linea
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CHARGE  = 2'd1,
        ST_MEASURE = 2'd2,
        ST_LATCH   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CHARGE_LAST = CNT_W'(CHARGE_CYC - 1);
    localparam logic [CNT_W-1:0] MEAS_LAST   = CNT_W'(PERIOD_CYC - 2);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] OUT_MAX     = CNT_W'((2 ** OUT_W) - 1);

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         fc_q, fc_d;
    logic [CNT_W-1:0]         cnt_q [N_CH];
    logic [CNT_W-1:0]         cnt_d [N_CH];
    logic                     pending_q, pending_d;
    logic [N_CH-1:0]          sync1_q, sync2_q;
    logic [N_CH*OUT_W-1:0]    dist_q, dist_d;
    logic [N_CH-1:0]          linea_q, linea_d;
    logic                     descarga_q, busy_q, valid_q;

    // Shift the raw count down and clamp it to the output field width.
    function automatic logic [OUT_W-1:0] scale_sat(input logic [CNT_W-1:0] c);
        logic [CNT_W-1:0] s;
        s = c >> SHIFT;
        if (s > OUT_MAX) begin
            return {OUT_W{1'b1}};
        end
        return s[OUT_W-1:0];
    endfunction

    // The pins are only ever driven high (charge); otherwise the RC node floats.
    assign ir_io = descarga_q ? {N_CH{1'b1}} : {N_CH{1'bz}};

    assign descarga  = descarga_q;
    assign busy      = busy_q;
    assign valid     = valid_q;
    assign distancia = dist_q;
    assign linea     = linea_q;

    // Next-state, frame counter, per-channel counting and result capture.
    always_comb begin
        state_d   = state_q;
        fc_d      = fc_q;
        pending_d = pending_q;
        dist_d    = dist_q;
        linea_d   = linea_q;
        for (int i = 0; i < N_CH; i++) begin
            cnt_d[i] = cnt_q[i];
        end

        case (state_q)
            ST_IDLE: begin
                fc_d      = '0;
                pending_d = 1'b0;
                for (int i = 0; i < N_CH; i++) begin
                    cnt_d[i] = '0;
                end
                if (CONTINUOUS || start) begin
                    state_d = ST_CHARGE;
                end
            end

            ST_CHARGE: begin
                fc_d = fc_q + CNT_W'(1);
                if (start) begin
                    pending_d = 1'b1;
                end
                if (fc_q == CHARGE_LAST) begin
                    state_d = ST_MEASURE;
                end
            end

            ST_MEASURE: begin
                fc_d = fc_q + CNT_W'(1);
                if (start) begin
                    pending_d = 1'b1;
                end
                for (int i = 0; i < N_CH; i++) begin
                    if (sync2_q[i] && (cnt_q[i] != CNT_MAX)) begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
                // Capture on entry to LATCH so the new fields, the flags and
                // the valid strobe all become visible in the same cycle.
                if (fc_q == MEAS_LAST) begin
                    state_d = ST_LATCH;
                    for (int i = 0; i < N_CH; i++) begin
                        dist_d[i*OUT_W +: OUT_W] = scale_sat(cnt_d[i]);
                        linea_d[i] = (scale_sat(cnt_d[i]) >= umbral);
                    end
                end
            end

            ST_LATCH: begin
                fc_d      = '0;
                pending_d = 1'b0;
                for (int i = 0; i < N_CH; i++) begin
                    cnt_d[i] = '0;
                end
                if (CONTINUOUS || pending_q || start) begin
                    state_d = ST_CHARGE;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counters, synchronisers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            fc_q       <= '0;
            pending_q  <= 1'b0;
            sync1_q    <= '0;
            sync2_q    <= '0;
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= '0;
            end
            dist_q     <= '0;
            linea_q    <= '0;
            descarga_q <= 1'b0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            fc_q       <= fc_d;
            pending_q  <= pending_d;
            sync1_q    <= ir_io;
            sync2_q    <= sync1_q;
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            dist_q     <= dist_d;
            linea_q    <= linea_d;
            descarga_q <= (state_d == ST_CHARGE);
            busy_q     <= (state_d != ST_IDLE);
            valid_q    <= (state_d == ST_LATCH);
        end
    end

endmodule

// File: tb/tb_ir_array_reader.sv
// Directed bench for ir_array_reader: continuous frame timing, discharge
// counting, mid-frame reset, count saturation with shift, and one-shot mode.
// Cycle numbering: cycle 0 is the first cycle in which rst is low; inputs
// change and outputs are sampled 1 time unit after each rising edge.

module tb_ir_array_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Continuous instance: CHARGE_CYC=4, PERIOD_CYC=20
    logic        rst_a, start_a;
    logic [7:0]  umb_a;
    logic [1:0]  lvl_a;
    wire  [1:0]  ir_a;
    logic        desc_a, busy_a, valid_a;
    logic [15:0] dist_a;
    logic [1:0]  linea_a;

    // Saturation instance: PERIOD_CYC=600, SHIFT=1
    logic        rst_s, start_s;
    logic [7:0]  umb_s;
    wire  [1:0]  ir_s;
    logic        desc_s, busy_s, valid_s;
    logic [15:0] dist_s;
    logic [1:0]  linea_s;

    // One-shot instance
    logic        rst_o, start_o;
    logic [7:0]  umb_o;
    wire  [1:0]  ir_o;
    logic        desc_o, busy_o, valid_o;
    logic [15:0] dist_o;
    logic [1:0]  linea_o;

    // Sensor model: releases the pin while the reader charges it, otherwise
    // presents the reflectance level chosen by the stimulus.
    assign ir_a = desc_a ? 2'bzz : lvl_a;
    assign ir_s = desc_s ? 2'bzz : 2'b11;
    assign ir_o = desc_o ? 2'bzz : 2'b11;

    ir_array_reader #(.N_CH(2), .CNT_W(16), .CHARGE_CYC(4), .PERIOD_CYC(20),
                      .OUT_W(8), .SHIFT(0), .CONTINUOUS(1'b1)) u_a (
        .clk(clk), .rst(rst_a), .start(start_a), .umbral(umb_a), .ir_io(ir_a),
        .descarga(desc_a), .busy(busy_a), .valid(valid_a),
        .distancia(dist_a), .linea(linea_a));

    ir_array_reader #(.N_CH(2), .CNT_W(16), .CHARGE_CYC(4), .PERIOD_CYC(600),
                      .OUT_W(8), .SHIFT(1), .CONTINUOUS(1'b1)) u_s (
        .clk(clk), .rst(rst_s), .start(start_s), .umbral(umb_s), .ir_io(ir_s),
        .descarga(desc_s), .busy(busy_s), .valid(valid_s),
        .distancia(dist_s), .linea(linea_s));

    ir_array_reader #(.N_CH(2), .CNT_W(16), .CHARGE_CYC(4), .PERIOD_CYC(20),
                      .OUT_W(8), .SHIFT(0), .CONTINUOUS(1'b0)) u_o (
        .clk(clk), .rst(rst_o), .start(start_o), .umbral(umb_o), .ir_io(ir_o),
        .descarga(desc_o), .busy(busy_o), .valid(valid_o),
        .distancia(dist_o), .linea(linea_o));

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int dcnt, vcnt, v1, v2, k;
    logic d1, b5, d10, d30, b9, b50;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_a = 1'b1; rst_s = 1'b1; rst_o = 1'b1;
        start_a = 1'b0; start_s = 1'b0; start_o = 1'b0;
        umb_a = 8'd5; umb_s = 8'd255; umb_o = 8'd5;
        lvl_a = 2'b11;

        // ---------------- reset and first frame ----------------
        tick(3);
        chk("rst_descarga", desc_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_valid", valid_a, 0);
        chk("rst_distancia", dist_a, 0);
        chk("rst_linea", linea_a, 0);

        rst_a = 1'b0;
        chk("c0_busy", busy_a, 0);
        dcnt = 0; vcnt = 0;
        for (int c = 0; c < 20; c++) begin
            if (desc_a) dcnt++;
            if (valid_a) vcnt++;
            if (c == 1) d1 = desc_a;
            if (c == 5) b5 = busy_a;
            tick(1);
        end
        // cycle 20: LATCH of the first frame
        chk("charge_cycles", dcnt, 4);
        chk("charge_first_c1", d1, 1);
        chk("measure_busy_c5", b5, 1);
        chk("no_early_valid", vcnt, 0);
        chk("f1_valid_c20", valid_a, 1);
        chk("f1_distancia", dist_a, 16'h0F0F);
        chk("f1_linea", linea_a, 2'b11);

        tick(1);
        // cycle 21: next frame charges immediately, results hold
        chk("c21_valid_low", valid_a, 0);
        chk("c21_descarga", desc_a, 1);
        chk("c21_hold", dist_a, 16'h0F0F);

        // ---------------- discharge timing ----------------
        // MEASURE starts at cycle 25: ch1 low from m=0, ch0 low from m=5
        for (int c = 21; c < 40; c++) begin
            if (c == 25) lvl_a[1] = 1'b0;
            if (c == 30) lvl_a[0] = 1'b0;
            tick(1);
        end
        chk("f2_valid_c40", valid_a, 1);
        chk("f2_distancia", dist_a, 16'h0207);
        chk("f2_linea", linea_a, 2'b01);
        lvl_a = 2'b11;

        // ---------------- mid-frame reset ----------------
        // frame 3: CHARGE 41..44, MEASURE from 45, so m=6 is cycle 51
        tick(11);
        rst_a = 1'b1;
        tick(1);
        chk("mrst_distancia", dist_a, 0);
        chk("mrst_busy", busy_a, 0);
        chk("mrst_linea", linea_a, 0);
        rst_a = 1'b0;
        vcnt = 0;
        for (int c = 0; c < 20; c++) begin
            if (valid_a) vcnt++;
            tick(1);
        end
        chk("mrst_no_valid", vcnt, 0);
        chk("mrst_restart_valid", valid_a, 1);
        chk("mrst_restart_dist", dist_a, 16'h0F0F);

        // ---------------- saturation and shift ----------------
        chk("sat_rst_dist", dist_s, 0);
        rst_s = 1'b0;
        k = 0;
        while (!valid_s && k <= 700) begin
            tick(1);
            k++;
        end
        // count 595, >>1 = 297, clamps to 255; umbral 255 is met exactly
        chk("sat_valid_cycle", k, 600);
        chk("sat_distancia", dist_s, 16'hFFFF);
        chk("sat_linea", linea_s, 2'b11);

        // ---------------- one-shot mode ----------------
        rst_o = 1'b0;
        vcnt = 0; v1 = -1; v2 = -1;
        for (int c = 0; c <= 90; c++) begin
            start_o = (c == 9 || c == 15 || c == 18);
            if (valid_o) begin
                vcnt++;
                if (v1 < 0) v1 = c;
                else if (v2 < 0) v2 = c;
            end
            if (c == 9)  b9  = busy_o;
            if (c == 10) d10 = desc_o;
            if (c == 30) d30 = desc_o;
            if (c == 50) b50 = busy_o;
            tick(1);
        end
        start_o = 1'b0;
        chk("os_idle_busy_c9", b9, 0);
        chk("os_charge_c10", d10, 1);
        chk("os_first_valid", v1, 29);
        chk("os_second_charge", d30, 1);
        chk("os_second_valid", v2, 49);
        chk("os_valid_count", vcnt, 2);
        chk("os_busy_c50", b50, 0);
        chk("os_busy_end", busy_o, 0);
        chk("os_distancia", dist_o, 16'h0F0F);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
